// File: rtl/legv8_pkg.sv
// Shared LEGv8 register-file widths, the zero-register index and the writeback grant encoding.
// Latency: none; this file holds types and constants only.
// Backpressure: none; this file holds types and constants only.
package legv8_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  // X31 reads as zero in this datapath, so writes to it are dropped.
  localparam logic [REG_AW-1:0] XZR_IDX = 5'd31;

  // Which writeback source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LD
  } gnt_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the register file, plus the read-after-write stall compare for decode.
// Latency: set/clear seen on PENDING the cycle after the edge; stall is combinational.
// Backpressure: none of its own; stall is the backpressure it produces toward decode.
module reg_scoreboard
  import legv8_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              iss_vld,
  input  logic [REG_AW-1:0] iss_reg,
  input  logic              clr_vld,
  input  logic [REG_AW-1:0] clr_reg,
  input  logic              wr_vld,
  input  logic [REG_AW-1:0] wr_reg,
  input  logic [REG_AW-1:0] chk_reg1,
  input  logic [REG_AW-1:0] chk_reg2,
  output logic [31:0]       pending,
  output logic              stall
);

  logic [31:0] pending_d;
  logic [31:0] pending_q;

  // Clear the granted destination first, then set the issuing one so a newer producer stays outstanding.
  always_comb begin
    pending_d = pending_q;
    if (clr_vld) begin
      pending_d[clr_reg] = 1'b0;
    end
    if (iss_vld && (iss_reg != XZR_IDX)) begin
      pending_d[iss_reg] = 1'b1;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Stall a source that is outstanding, or that is being written this cycle while the file still returns old data.
  always_comb begin
    stall = 1'b0;
    if ((chk_reg1 != XZR_IDX) && (pending_q[chk_reg1] || (wr_vld && (wr_reg == chk_reg1)))) begin
      stall = 1'b1;
    end
    if ((chk_reg2 != XZR_IDX) && (pending_q[chk_reg2] || (wr_vld && (wr_reg == chk_reg2)))) begin
      stall = 1'b1;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/reg_wr_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port; ALU has priority, loads have a starvation guard.
// Latency: the accept edge drives REG_WRITE/WR_REG/WR_DATA for exactly the next cycle.
// Backpressure: combinational READY goes only to the winner; a loser holds VALID/REG/DATA until it is accepted.
module reg_wr_arbiter
  import legv8_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ISS_VALID,
  input  logic [REG_AW-1:0] ISS_REG,
  input  logic              ALU_VALID,
  output logic              ALU_READY,
  input  logic [REG_AW-1:0] ALU_REG,
  input  logic [XLEN-1:0]   ALU_DATA,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [REG_AW-1:0] LD_REG,
  input  logic [XLEN-1:0]   LD_DATA,
  output logic              REG_WRITE,
  output logic [REG_AW-1:0] WR_REG,
  output logic [XLEN-1:0]   WR_DATA,
  input  logic [REG_AW-1:0] CHK_REG1,
  input  logic [REG_AW-1:0] CHK_REG2,
  output logic              STALL,
  output logic [31:0]       PENDING
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  gnt_e              gnt;
  logic [REG_AW-1:0] win_reg;
  logic [XLEN-1:0]   win_data;

  logic [3:0]        starve_cnt_d, starve_cnt_q;
  logic              reg_write_d, reg_write_q;
  logic [REG_AW-1:0] wr_reg_d, wr_reg_q;
  logic [XLEN-1:0]   wr_data_d, wr_data_q;

  // Pick at most one winner: a starved load first, then the ALU, then any load; nobody while in reset.
  always_comb begin
    gnt = GNT_NONE;
    if (!RST_N) begin
      gnt = GNT_NONE;
    end else if (LD_VALID && (starve_cnt_q >= STARVE_LIM)) begin
      gnt = GNT_LD;
    end else if (ALU_VALID) begin
      gnt = GNT_ALU;
    end else if (LD_VALID) begin
      gnt = GNT_LD;
    end
  end

  // Route the winner's destination and data toward the output register and scoreboard clear.
  always_comb begin
    win_reg  = ALU_REG;
    win_data = ALU_DATA;
    if (gnt == GNT_LD) begin
      win_reg  = LD_REG;
      win_data = LD_DATA;
    end
  end

  // Next state: count consecutive load losses, and latch the winner into the write-port register.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (LD_VALID && (gnt != GNT_LD)) begin
      starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
    end
    reg_write_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (gnt != GNT_NONE) begin
      wr_reg_d    = win_reg;
      wr_data_d   = win_data;
      reg_write_d = (win_reg != XZR_IDX);
    end
  end

  // Starve counter and write-port register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve_cnt_q <= 4'd0;
      reg_write_q  <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      reg_write_q  <= reg_write_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign ALU_READY = (gnt == GNT_ALU);
  assign LD_READY  = (gnt == GNT_LD);
  assign REG_WRITE = reg_write_q;
  assign WR_REG    = wr_reg_q;
  assign WR_DATA   = wr_data_q;

  reg_scoreboard u_scoreboard (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .iss_vld  (ISS_VALID),
    .iss_reg  (ISS_REG),
    .clr_vld  (gnt != GNT_NONE),
    .clr_reg  (win_reg),
    .wr_vld   (reg_write_q),
    .wr_reg   (wr_reg_q),
    .chk_reg1 (CHK_REG1),
    .chk_reg2 (CHK_REG2),
    .pending  (PENDING),
    .stall    (STALL)
  );

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
// Latency: the model predicts registered outputs one cycle after each accept.
// Backpressure: requesters hold VALID/REG/DATA until the model says they were accepted.
module tb_reg_wr_arbiter;

  localparam int SM = 3;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ISS_VALID;
  logic [4:0]  ISS_REG;
  logic        ALU_VALID;
  logic        ALU_READY;
  logic [4:0]  ALU_REG;
  logic [63:0] ALU_DATA;
  logic        LD_VALID;
  logic        LD_READY;
  logic [4:0]  LD_REG;
  logic [63:0] LD_DATA;
  logic        REG_WRITE;
  logic [4:0]  WR_REG;
  logic [63:0] WR_DATA;
  logic [4:0]  CHK_REG1;
  logic [4:0]  CHK_REG2;
  logic        STALL;
  logic [31:0] PENDING;

  always #5 CLK = ~CLK;

  reg_wr_arbiter #(.STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ISS_VALID(ISS_VALID), .ISS_REG(ISS_REG),
    .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_REG(ALU_REG), .ALU_DATA(ALU_DATA),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_REG(LD_REG), .LD_DATA(LD_DATA),
    .REG_WRITE(REG_WRITE), .WR_REG(WR_REG), .WR_DATA(WR_DATA),
    .CHK_REG1(CHK_REG1), .CHK_REG2(CHK_REG2), .STALL(STALL), .PENDING(PENDING)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outstanding-write set, losses of the current load, and the last write presented to the file.
  bit          m_pend [32];
  int          m_wait;
  bit          m_rw;
  logic [4:0]  m_wr_reg;
  logic [63:0] m_wr_data;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_wait    = 0;
    m_rw      = 1'b0;
    m_wr_reg  = '0;
    m_wr_data = '0;
  endfunction

  // 0 = nobody, 1 = ALU, 2 = load
  function automatic int m_grant();
    if (RST_N !== 1'b1) return 0;
    if (LD_VALID && (m_wait >= SM)) return 2;
    if (ALU_VALID) return 1;
    if (LD_VALID) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] m_pvec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit m_hazard(input logic [4:0] c);
    if (c == 5'd31) return 1'b0;
    return m_pend[c] || (m_rw && (m_wr_reg == c));
  endfunction

  function automatic void m_step();
    int g;
    logic [4:0] r;
    logic [63:0] d;
    g = m_grant();
    if (LD_VALID && (g != 2)) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    else m_wait = 0;
    if (g != 0) begin
      r = (g == 1) ? ALU_REG : LD_REG;
      d = (g == 1) ? ALU_DATA : LD_DATA;
      m_wr_reg  = r;
      m_wr_data = d;
      m_rw      = (r != 5'd31);
      m_pend[r] = 1'b0;
    end else begin
      m_rw = 1'b0;
    end
    if (ISS_VALID && (ISS_REG != 5'd31)) m_pend[ISS_REG] = 1'b1;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or negedge RST_N);
      if (RST_N !== 1'b1) m_reset();
      else m_step();
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        check("cmp_alu_ready", ALU_READY, (m_grant() == 1));
        check("cmp_ld_ready",  LD_READY,  (m_grant() == 2));
        check("cmp_reg_write", REG_WRITE, m_rw);
        check("cmp_wr_reg",    WR_REG,    m_wr_reg);
        check("cmp_wr_data",   WR_DATA,   m_wr_data);
        check("cmp_pending",   PENDING,   m_pvec());
        check("cmp_stall",     STALL,     m_hazard(CHK_REG1) || m_hazard(CHK_REG2));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int g;
    RST_N = 1'b0;
    ISS_VALID = 1'b0; ISS_REG = '0;
    ALU_VALID = 1'b0; ALU_REG = '0; ALU_DATA = '0;
    LD_VALID  = 1'b0; LD_REG  = '0; LD_DATA  = '0;
    CHK_REG1 = '0; CHK_REG2 = '0;
    cmp_en = 1'b1;

    @(negedge CLK);
    check("rst_reg_write", REG_WRITE, 1'b0);
    check("rst_pending", PENDING, 32'h0);
    check("rst_alu_ready", ALU_READY, 1'b0);
    #2 RST_N = 1'b1;
    step();

    // ALU only
    ALU_VALID = 1'b1; ALU_REG = 5'd5; ALU_DATA = 64'hDEAD;
    @(negedge CLK);
    check("alu_ready", ALU_READY, 1'b1);
    check("alu_ld_ready", LD_READY, 1'b0);
    step();
    ALU_VALID = 1'b0;
    @(negedge CLK);
    check("alu_reg_write", REG_WRITE, 1'b1);
    check("alu_wr_reg", WR_REG, 5'd5);
    check("alu_wr_data", WR_DATA, 64'hDEAD);
    step();
    @(negedge CLK);
    check("idle_reg_write", REG_WRITE, 1'b0);
    check("idle_wr_reg_hold", WR_REG, 5'd5);
    step();

    // Contention: ALU wins three times, load wins the fourth
    ALU_VALID = 1'b1; ALU_REG = 5'd3; ALU_DATA = 64'h1;
    LD_VALID  = 1'b1; LD_REG  = 5'd7; LD_DATA  = 64'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("cont_ld_ready_%0d", i), LD_READY, (i == 3));
      check($sformatf("cont_alu_ready_%0d", i), ALU_READY, (i != 3));
      step();
      if (i == 3) LD_VALID = 1'b0;
    end
    @(negedge CLK);
    check("cont_wr_reg", WR_REG, 5'd7);
    check("cont_wr_data", WR_DATA, 64'h77);
    check("cont_starve_clr", dut.starve_cnt_q, 4'd0);
    check("cont_alu_after", ALU_READY, 1'b1);
    step();

    // XZR
    ALU_VALID = 1'b0;
    LD_VALID = 1'b1; LD_REG = 5'd31; LD_DATA = 64'h5;
    ISS_VALID = 1'b1; ISS_REG = 5'd31; CHK_REG1 = 5'd31; CHK_REG2 = 5'd0;
    @(negedge CLK);
    check("xzr_ld_ready", LD_READY, 1'b1);
    check("xzr_stall", STALL, 1'b0);
    step();
    LD_VALID = 1'b0; ISS_VALID = 1'b0;
    @(negedge CLK);
    check("xzr_reg_write", REG_WRITE, 1'b0);
    check("xzr_pending", PENDING, 32'h0);
    step();

    // Scoreboard on X9
    ISS_VALID = 1'b1; ISS_REG = 5'd9; CHK_REG1 = 5'd0; CHK_REG2 = 5'd9;
    @(negedge CLK);
    check("sb_stall_pre", STALL, 1'b0);
    step();
    ISS_VALID = 1'b0;
    @(negedge CLK);
    check("sb_pending9", PENDING, 32'h0000_0200);
    check("sb_stall_1", STALL, 1'b1);
    step();
    LD_VALID = 1'b1; LD_REG = 5'd9; LD_DATA = 64'h99;
    @(negedge CLK);
    check("sb_ld_ready", LD_READY, 1'b1);
    check("sb_stall_2", STALL, 1'b1);
    step();
    LD_VALID = 1'b0;
    @(negedge CLK);
    check("sb_rw", REG_WRITE, 1'b1);
    check("sb_wr_reg", WR_REG, 5'd9);
    check("sb_pending_clr", PENDING, 32'h0);
    check("sb_stall_wr", STALL, 1'b1);
    step();
    @(negedge CLK);
    check("sb_stall_after", STALL, 1'b0);
    step();

    // Set and clear of X4 on the same edge
    ISS_VALID = 1'b1; ISS_REG = 5'd4;
    ALU_VALID = 1'b1; ALU_REG = 5'd4; ALU_DATA = 64'h44;
    @(negedge CLK);
    check("sim_alu_ready", ALU_READY, 1'b1);
    step();
    ISS_VALID = 1'b0; ALU_VALID = 1'b0;
    @(negedge CLK);
    check("sim_pending4", PENDING, 32'h0000_0010);
    check("sim_rw", REG_WRITE, 1'b1);
    step();

    // Reset mid-stream
    ISS_VALID = 1'b1; ISS_REG = 5'd9;
    ALU_VALID = 1'b1; ALU_REG = 5'd2; ALU_DATA = 64'h22;
    step();
    ISS_VALID = 1'b0;
    @(negedge CLK);
    check("mid_pending", PENDING, 32'h0000_0210);
    check("mid_rw", REG_WRITE, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_rw", REG_WRITE, 1'b0);
    check("mid_rst_wr_reg", WR_REG, 5'd0);
    check("mid_rst_wr_data", WR_DATA, 64'h0);
    check("mid_rst_pending", PENDING, 32'h0);
    check("mid_rst_alu_ready", ALU_READY, 1'b0);
    ALU_VALID = 1'b0;
    @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    check("mid_post_pending", PENDING, 32'h0);
    check("mid_post_rw", REG_WRITE, 1'b0);
    step();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      g = m_grant();
      if (cyc == 1500) begin
        #2 RST_N = 1'b0;
        @(negedge CLK);
        ALU_VALID = 1'b0; LD_VALID = 1'b0; ISS_VALID = 1'b0;
        #2 RST_N = 1'b1;
        g = 0;
      end
      step();
      if (ALU_VALID && (g == 1)) ALU_VALID = 1'b0;
      if (LD_VALID && (g == 2)) LD_VALID = 1'b0;
      if (!ALU_VALID && ($urandom_range(0, 9) < 8)) begin
        ALU_VALID = 1'b1;
        ALU_REG   = 5'($urandom_range(0, 31));
        ALU_DATA  = {$urandom, $urandom};
      end
      if (!LD_VALID && ($urandom_range(0, 9) < 5)) begin
        LD_VALID = 1'b1;
        LD_REG   = 5'($urandom_range(0, 31));
        LD_DATA  = {$urandom, $urandom};
      end
      ISS_VALID = ($urandom_range(0, 2) == 0);
      ISS_REG   = 5'($urandom_range(0, 31));
      CHK_REG1  = 5'($urandom_range(0, 31));
      CHK_REG2  = 5'($urandom_range(0, 31));
    end

    @(negedge CLK);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Write-port arbiter and scoreboard for the 32×64-bit LEGv8 register file. Two writeback sources, the single-cycle ALU path and the variable-latency load unit, share the file's single write port. Fixed ALU priority applies, with a starvation guard for loads. A pending-write scoreboard drives a read-after-write STALL back to decode.

## Interface
- STARVE_MAX, 3: consecutive cycles a valid load may lose arbitration before it is forced to win; range 1..15.

- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- ISS_VALID  in  1  instruction with a destination register issued this cycle
- ISS_REG  in  5  destination of issuing instruction
- ALU_VALID  in  1  ALU writeback request
- ALU_READY  out  1  ALU request accepted this cycle
- ALU_REG  in  5  ALU destination
- ALU_DATA  in  64  ALU result
- LD_VALID  in  1  load writeback request
- LD_READY  out  1  load request accepted this cycle
- LD_REG  in  5  load destination
- LD_DATA  in  64  load data
- REG_WRITE  out  1  write enable to register file
- WR_REG  out  5  write address to register file
- WR_DATA  out  64  write data to register file
- CHK_REG1  in  5  decode source register 1
- CHK_REG2  in  5  decode source register 2
- STALL  out  1  a source register has an outstanding or in-flight write
- PENDING  out  32  scoreboard vector, bit n = Xn write outstanding

## Operation
- Handshake: a transfer occurs on a rising edge when VALID and READY are both high. VALID must not depend on READY. A requester holds VALID, REG and DATA stable until accepted.
- Grant, combinational, at most one per cycle:
  - LD wins if LD_VALID and starve_cnt ≥ STARVE_MAX.
  - Otherwise ALU wins if ALU_VALID.
  - Otherwise LD wins if LD_VALID.
  - READY is high only for the granted source.
- starve_cnt (4 bits):
  - Increments, saturating at 15, on each edge where LD_VALID is high and the load is not granted.
  - Clears on load grant or when LD_VALID is low.
- Output register:
  - On a grant, WR_REG/WR_DATA load the winner's REG/DATA.
  - REG_WRITE is 1 unless the destination is 31 (XZR). For XZR the handshake completes but REG_WRITE is 0.
  - With no grant, REG_WRITE returns to 0; WR_REG/WR_DATA hold their values.
- Scoreboard:
  - On ISS_VALID with ISS_REG≠31, set PENDING[ISS_REG].
  - On a grant, clear PENDING[granted REG].
  - Set and clear of the same bit on the same edge: set wins (newer producer outstanding).
  - Clearing an already-clear bit is legal, with no side effect.
- STALL, combinational: for each c in {CHK_REG1, CHK_REG2}, STALL is 1 when c≠31 and either PENDING[c] is set or (REG_WRITE and WR_REG==c).
  - The second term covers the cycle in which the file is written but still reads old data.
- Reset, asynchronous:
  - REG_WRITE=0, WR_REG=0, WR_DATA=0, PENDING=0, starve_cnt=0.
  - ALU_READY and LD_READY are forced 0 while RST_N is low.
  - Reset mid-transfer discards the write; requesters re-present after reset.

## Timing
- Latency: handshake edge → REG_WRITE/WR_REG/WR_DATA valid for exactly the following cycle. The file captures the write on the next edge.
- Throughput: one write per cycle, back-to-back grants allowed.
- Maximum load wait while ALU_VALID is continuously high: STARVE_MAX cycles, granted in cycle STARVE_MAX+1.
- STALL, ALU_READY and LD_READY are combinational. All other outputs are registered.
- Issue to STALL on the same register: STALL is high from the cycle after ISS_VALID until the REG_WRITE cycle, inclusive.

## Structure
- Shared package legv8_pkg holds:
  - XLEN=64, REG_AW=5, XZR_IDX=5'd31.
  - Grant enum typedef gnt_e {GNT_NONE, GNT_ALU, GNT_LD}.
- Sub-module reg_scoreboard holds PENDING set/clear and STALL compare logic. It is instantiated once. Arbitration, starve counter and output register stay in the top module.

## Test plan
- ALU only: ALU_VALID=1, ALU_REG=5, ALU_DATA=64'hDEAD → ALU_READY=1 that cycle; next cycle REG_WRITE=1, WR_REG=5, WR_DATA=64'hDEAD.
- Contention with STARVE_MAX=3:
  - Stimulus: ALU_VALID and LD_VALID held high, LD_REG=7.
  - ALU is granted 3 cycles; LD_READY=1 in the 4th; starve_cnt returns to 0.
- XZR:
  - LD_REG=31 accepted → LD_READY=1, REG_WRITE stays 0.
  - ISS_REG=31 → PENDING unchanged.
  - CHK_REG1=31 → STALL=0.
- Scoreboard:
  - ISS_VALID, ISS_REG=9 → PENDING[9]=1 next cycle.
  - CHK_REG2=9 → STALL=1 until load of X9 is written.
  - STALL=1 also in the REG_WRITE cycle, 0 the cycle after.
- Simultaneous: ISS_REG=4 and ALU grant with ALU_REG=4 on the same edge → PENDING[4]=1 afterwards.
- Reset mid-stream: RST_N low while REG_WRITE=1 and PENDING=32'h0000_0210 → all outputs 0 immediately, READYs 0, PENDING=0 after release.
